// File: rtl/obi_dma_copy.sv
// Single-channel OBI word copier: reads one word from src, writes it to dst,
// repeats len times with at most one bus transaction outstanding.
module obi_dma_copy #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [31:0]          src_addr_i,
    input  logic [31:0]          dst_addr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 req_o,
    input  logic                 gnt_i,
    output logic [31:0]          addr_o,
    output logic                 we_o,
    output logic [3:0]           be_o,
    output logic [31:0]          wdata_o,
    input  logic                 rvalid_i,
    input  logic [31:0]          rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [31:0]          r_src;
    logic [31:0]          r_dst;
    logic [31:0]          r_buf;
    logic [31:0]          r_addr;
    logic [LEN_WIDTH-1:0] r_rem;
    logic                 r_req;
    logic                 r_we;
    logic                 r_busy;
    logic                 r_done;

    // Bus outputs are registered and only change on state transitions, so an
    // ungranted request keeps addr/we/wdata stable by construction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_buf   <= '0;
            r_addr  <= '0;
            r_rem   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_src  <= src_addr_i & 32'hFFFF_FFFC;
                        r_dst  <= dst_addr_i & 32'hFFFF_FFFC;
                        r_rem  <= len_i;
                        r_busy <= 1'b1;
                        if (len_i == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RD_REQ;
                            r_req   <= 1'b1;
                            r_we    <= 1'b0;
                            r_addr  <= src_addr_i & 32'hFFFF_FFFC;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (gnt_i) begin
                        r_state <= S_RD_WAIT;
                        r_req   <= 1'b0;
                    end
                end
                S_RD_WAIT: begin
                    if (rvalid_i) begin
                        r_buf   <= rdata_i;
                        r_state <= S_WR_REQ;
                        r_req   <= 1'b1;
                        r_we    <= 1'b1;
                        r_addr  <= r_dst;
                    end
                end
                S_WR_REQ: begin
                    if (gnt_i) begin
                        r_state <= S_WR_WAIT;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                    end
                end
                S_WR_WAIT: begin
                    if (rvalid_i) begin
                        if (r_rem == LEN_WIDTH'(1)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            // Pointers wrap naturally at 2^32.
                            r_rem   <= r_rem - LEN_WIDTH'(1);
                            r_src   <= r_src + 32'd4;
                            r_dst   <= r_dst + 32'd4;
                            r_state <= S_RD_REQ;
                            r_req   <= 1'b1;
                            r_addr  <= r_src + 32'd4;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign req_o   = r_req;
    assign we_o    = r_we;
    assign addr_o  = r_addr;
    assign wdata_o = r_buf;
    assign be_o    = 4'hF;

endmodule

// File: tb/tb_obi_dma_copy.sv
// Randomised bench for obi_dma_copy: an OBI responder with configurable stalls
// and latency, plus a transaction-level model of the expected copy sequence.
module tb_obi_dma_copy;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [15:0] len_i = '0;
    logic        busy_o, done_o, req_o, we_o;
    logic        gnt_i = 1'b0;
    logic [31:0] addr_o, wdata_o;
    logic [3:0]  be_o;
    logic        rvalid_i = 1'b0;
    logic [31:0] rdata_i = '0;

    obi_dma_copy #(.LEN_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .req_o(req_o), .gnt_i(gnt_i),
        .addr_o(addr_o), .we_o(we_o), .be_o(be_o), .wdata_o(wdata_o),
        .rvalid_i(rvalid_i), .rdata_i(rdata_i)
    );

    initial forever #5 clk_i = ~clk_i;

    int cyc = 0;
    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        bit          last;
    } op_t;

    int checks = 0;
    int errors = 0;

    op_t         exp_q[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] rd_log[$];
    bit          exp_busy = 0;
    int          done_due = -1;
    logic [31:0] last_addr = '0;
    logic [31:0] model_buf = '0;
    bit          outst = 0;
    bit          o_we, o_last;
    logic [31:0] o_addr;
    int          resp_wait = 0;
    int          stall_cnt = 0;
    int          fixed_stall = 0;
    int          max_stall = 0;
    int          max_lat = 0;
    bit          noise = 0;
    int          done_cnt = 0;
    int          last_done_cyc = -1;
    int          first_req_cyc = -1;
    int          req_cycles = 0;
    int          busy_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int pick_stall();
        if (fixed_stall >= 0) return fixed_stall;
        return int'($urandom_range(0, max_stall));
    endfunction

    // Responder + model + compare, all on the falling edge.
    initial begin : resp_chk
        op_t         op;
        logic [31:0] s, d;
        int          n;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                chk("rst_req", {31'd0, req_o}, 32'd0);
                chk("rst_busy", {31'd0, busy_o}, 32'd0);
                chk("rst_done", {31'd0, done_o}, 32'd0);
                chk("rst_we", {31'd0, we_o}, 32'd0);
                chk("rst_addr", addr_o, 32'd0);
                chk("rst_wdata", wdata_o, 32'd0);
                exp_q.delete();
                exp_busy = 0; done_due = -1; last_addr = '0; model_buf = '0;
                outst = 0; gnt_i = 0; rvalid_i = 0; rdata_i = '0;
            end else begin
                chk("busy", {31'd0, busy_o}, {31'd0, exp_busy});
                chk("done", {31'd0, done_o}, {31'd0, (cyc == done_due)});
                chk("be", {28'd0, be_o}, 32'hF);
                chk("wdata_buf", wdata_o, model_buf);
                if (req_o) begin
                    req_cycles++;
                    if (first_req_cyc < 0) first_req_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk("spurious_req", {31'd0, req_o}, 32'd0);
                    end else begin
                        chk("we", {31'd0, we_o}, {31'd0, exp_q[0].we});
                        chk("addr", addr_o, exp_q[0].addr);
                        if (exp_q[0].we) chk("wdata", wdata_o, exp_q[0].data);
                        last_addr = exp_q[0].addr;
                    end
                end else begin
                    chk("we_idle", {31'd0, we_o}, 32'd0);
                    chk("addr_hold", addr_o, last_addr);
                end
                if (busy_o) busy_cycles++;
                if (done_o) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                end
                if (cyc == done_due) exp_busy = 0;

                rvalid_i = 0;
                rdata_i  = $urandom;
                if (outst) begin
                    if (resp_wait == 0) begin
                        rvalid_i = 1;
                        outst = 0;
                        if (!o_we) begin
                            rdata_i   = mem_rd(o_addr);
                            model_buf = rdata_i;
                        end else if (o_last) begin
                            done_due = cyc + 1;
                        end
                    end else begin
                        resp_wait--;
                    end
                end else if (noise) begin
                    rvalid_i = ($urandom_range(0, 3) == 0);
                end

                gnt_i = 0;
                if (req_o && exp_q.size() > 0) begin
                    if (stall_cnt > 0) begin
                        stall_cnt--;
                    end else begin
                        gnt_i = 1;
                        op = exp_q.pop_front();
                        outst = 1; o_we = op.we; o_addr = op.addr; o_last = op.last;
                        resp_wait = int'($urandom_range(0, max_lat));
                        stall_cnt = pick_stall();
                        if (op.we) mem[op.addr] = wdata_o;
                        else rd_log.push_back(op.addr);
                    end
                end else if (!req_o && noise) begin
                    gnt_i = $urandom_range(0, 1) == 1;
                end

                if (start_i && !exp_busy) begin
                    exp_busy = 1;
                    s = src_addr_i & 32'hFFFF_FFFC;
                    d = dst_addr_i & 32'hFFFF_FFFC;
                    n = int'(len_i);
                    if (n == 0) done_due = cyc + 1;
                    for (int k = 0; k < n; k++) begin
                        exp_q.push_back('{1'b0, s + 32'(4 * k), 32'd0, 1'b0});
                        exp_q.push_back('{1'b1, d + 32'(4 * k), mem_rd(s + 32'(4 * k)), k == n - 1});
                    end
                    stall_cnt = pick_stall();
                end
            end
        end
    end

    task automatic start_cmd(input logic [31:0] s, input logic [31:0] d, input int n, output int c0);
        @(posedge clk_i); #1;
        src_addr_i = s; dst_addr_i = d; len_i = n[15:0]; start_i = 1;
        first_req_cyc = -1; req_cycles = 0; busy_cycles = 0; rd_log.delete();
        c0 = cyc;
        @(posedge clk_i); #1;
        start_i = 0;
    endtask

    task automatic wait_done(input int c0, output int rel);
        int  n0;
        bit  got;
        n0 = done_cnt;
        got = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_i); #1;
            if (done_cnt != n0) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
            rel = -1;
        end else begin
            rel = last_done_cyc - c0;
        end
    endtask

    initial begin : main
        int c0, rel, n;
        logic [31:0] s, d;

        fixed_stall = 0; max_lat = 0; noise = 0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1;
        repeat (2) @(posedge clk_i);

        // Zero-wait len=3 copy with preloaded source words.
        mem[32'h100] = 32'hA; mem[32'h104] = 32'hB; mem[32'h108] = 32'hC;
        start_cmd(32'h100, 32'h200, 3, c0);
        wait_done(c0, rel);
        chk("len3_done_cycle", 32'(rel), 32'd13);
        chk("len3_first_req", 32'(first_req_cyc - c0), 32'd1);
        @(negedge clk_i); #1;
        chk("len3_busy_c14", {31'd0, busy_o}, 32'd0);
        chk("mem_200", mem_rd(32'h200), 32'hA);
        chk("mem_204", mem_rd(32'h204), 32'hB);
        chk("mem_208", mem_rd(32'h208), 32'hC);

        // len=0: immediate done, no bus activity.
        start_cmd(32'h300, 32'h400, 0, c0);
        wait_done(c0, rel);
        chk("len0_done_cycle", 32'(rel), 32'd1);
        repeat (3) @(negedge clk_i);
        chk("len0_no_req", 32'(req_cycles), 32'd0);
        chk("len0_busy_cycles", 32'(busy_cycles), 32'd1);

        // Grant withheld three cycles on both read and write.
        fixed_stall = 3;
        mem[32'h500] = 32'hDEAD_BEEF;
        start_cmd(32'h500, 32'h600, 1, c0);
        wait_done(c0, rel);
        chk("stall_done_cycle", 32'(rel), 32'd11);
        chk("stall_req_cycles", 32'(req_cycles), 32'd8);
        chk("stall_mem_600", mem_rd(32'h600), 32'hDEAD_BEEF);
        fixed_stall = 0;

        // Source pointer wraps at 2^32.
        start_cmd(32'hFFFF_FFFC, 32'h700, 2, c0);
        wait_done(c0, rel);
        chk("wrap_rd0", rd_log.size() > 0 ? rd_log[0] : 32'hX, 32'hFFFF_FFFC);
        chk("wrap_rd1", rd_log.size() > 1 ? rd_log[1] : 32'hX, 32'h0);
        chk("wrap_done_cycle", 32'(rel), 32'd9);

        // Unaligned addresses, plus a start pulse while busy.
        mem[32'h100] = 32'h1234_5678;
        start_cmd(32'h103, 32'h202, 1, c0);
        @(posedge clk_i); #1;
        src_addr_i = 32'h900; dst_addr_i = 32'hA00; len_i = 16'd4; start_i = 1;
        @(posedge clk_i); #1;
        start_i = 0;
        wait_done(c0, rel);
        chk("unal_rd_addr", rd_log.size() > 0 ? rd_log[0] : 32'hX, 32'h100);
        chk("unal_mem_200", mem_rd(32'h200), 32'h1234_5678);
        chk("unal_done_cycle", 32'(rel), 32'd5);
        chk("unal_req_cycles", 32'(req_cycles), 32'd2);

        // Reset while a write request is pending.
        fixed_stall = 5;
        start_cmd(32'hB00, 32'hC00, 2, c0);
        for (int i = 0; i < 100 && !(req_o && we_o); i++) begin
            @(negedge clk_i); #1;
        end
        chk("rst_reached_wr", {31'd0, req_o && we_o}, 32'd1);
        rst_ni = 0;
        #1;
        chk("rst_req_now", {31'd0, req_o}, 32'd0);
        chk("rst_busy_now", {31'd0, busy_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1;
        req_cycles = 0;
        repeat (10) @(negedge clk_i);
        chk("rst_no_resume", 32'(req_cycles), 32'd0);
        fixed_stall = 0;
        start_cmd(32'hD00, 32'hE00, 1, c0);
        wait_done(c0, rel);
        chk("post_rst_done", 32'(rel), 32'd5);

        // Randomised copies with stalls, latency and bus noise.
        fixed_stall = -1; max_stall = 3; max_lat = 3; noise = 1;
        for (int t = 0; t < 20; t++) begin
            s = 32'h1000 + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
            d = 32'h8000 + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
            n = int'($urandom_range(0, 6));
            start_cmd(s, d, n, c0);
            wait_done(c0, rel);
            repeat ($urandom_range(0, 3)) @(posedge clk_i);
        end
        noise = 0;
        repeat (5) @(posedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obi_dma_copy.md
OBI_DMA_COPY -- requirements
Module: obi_dma_copy

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 16: width of the word-count input.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start_i  input  1  command strobe; sampled only in IDLE.
REQ-005 SHALL have port src_addr_i  input  32  source byte address; bits [1:0] are ignored.
REQ-006 SHALL have port dst_addr_i  input  32  destination byte address; bits [1:0] are ignored.
REQ-007 SHALL have port len_i  input  LEN_WIDTH  number of 32-bit words to copy.
REQ-008 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-009 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port req_o  output  1  OBI request.
REQ-011 SHALL have port gnt_i  input  1  OBI grant.
REQ-012 SHALL have port addr_o  output  32  OBI byte address; bits [1:0] always 0.
REQ-013 SHALL have port we_o  output  1  OBI write enable.
REQ-014 SHALL have port be_o  output  4  OBI byte enables; constant 4'hF.
REQ-015 SHALL have port wdata_o  output  32  OBI write data.
REQ-016 SHALL have port rvalid_i  input  1  OBI response valid, for both reads and writes.
REQ-017 SHALL have port rdata_i  input  32  OBI read data; valid when rvalid_i is high.

Function
REQ-018 SHALL implement the states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT and DONE.
REQ-019 IDLE with start_i=1: SHALL latch {src[31:2],2'b0}, {dst[31:2],2'b0} and len_i; next state is DONE if len_i==0, else RD_REQ.
REQ-020 SHALL ignore start_i in every state other than IDLE.
REQ-021 RD_REQ: SHALL drive req_o=1, we_o=0 and addr_o=src pointer; on gnt_i=1 move to RD_WAIT, otherwise hold all OBI outputs stable.
REQ-022 RD_WAIT: SHALL drive req_o=0; on rvalid_i=1 register rdata_i into the data buffer and move to WR_REQ.
REQ-023 WR_REQ: SHALL drive req_o=1, we_o=1, addr_o=dst pointer and wdata_o=data buffer; on gnt_i=1 move to WR_WAIT, otherwise hold outputs stable.
REQ-024 WR_WAIT: SHALL drive req_o=0; on rvalid_i=1 with remaining==1 move to DONE.
REQ-025 WR_WAIT: on rvalid_i=1 with remaining>1, SHALL decrement remaining, add 4 to both pointers and move to RD_REQ.
REQ-026 DONE: SHALL assert done_o=1 for exactly one cycle, then move to IDLE.
REQ-027 SHALL keep at most one OBI transaction outstanding; req_o SHALL never be high in RD_WAIT, WR_WAIT, DONE or IDLE.
REQ-028 SHALL ignore rvalid_i in the REQ, IDLE and DONE states, and ignore gnt_i in the WAIT states.
REQ-029 SHALL increment pointers modulo 2^32; e.g. 32'hFFFF_FFFC + 4 = 32'h0.
REQ-030 SHALL drive we_o=0 in every state except WR_REQ.
REQ-031 SHALL drive addr_o from the src pointer in RD_REQ and from the dst pointer in WR_REQ.
REQ-032 When req_o is low, SHALL drive addr_o as the last driven value and wdata_o as the buffer contents.
REQ-033 With a zero-wait responder (gnt same cycle, rvalid next cycle), each word SHALL take exactly 4 cycles.
REQ-034 Timing for len=N, N>0, with a zero-wait responder: start sampled at edge 0, req_o first high in cycle 1, done_o high in cycle 4N+1.
REQ-035 len=0: done_o SHALL be high in cycle 1 with no OBI request issued.

Reset
REQ-036 On rst_ni low, SHALL immediately, and regardless of clock, set the state to IDLE and clear to 0: req_o, we_o, addr_o, wdata_o, busy_o, done_o, the data buffer, the pointers and remaining.
REQ-037 Reset during any state SHALL abort the copy and drop req_o in the same cycle; on reset release no transaction resumes.

Verification
REQ-038 Scenario: src=0x100, dst=0x200, len=3, zero-wait responder preloaded {0xA,0xB,0xC} -> dst words 0x200/0x204/0x208 = 0xA/0xB/0xC; done_o in cycle 13; busy_o low in cycle 14.
REQ-039 Scenario: len=0 -> no req_o; done_o in cycle 1 only; busy_o high in cycle 1 only.
REQ-040 Scenario: gnt_i held low for 3 cycles in RD_REQ and in WR_REQ -> req_o, addr_o, we_o and wdata_o remain constant until the grant; data still copied correctly.
REQ-041 Scenario: src=0xFFFF_FFFC, len=2 -> read addresses are 0xFFFF_FFFC then 0x0000_0000.
REQ-042 Scenario: src=0x103, dst=0x202 -> addr_o = 0x100 / 0x200; start_i pulsed while busy -> no effect.
REQ-043 Scenario: rst_ni asserted in WR_REQ with req_o=1 -> req_o=0 and busy_o=0 immediately; after release, no request until a new start_i.
